// File: rtl/button_debounce_sync.sv
// Push-button conditioner: 2-flop sync, per-lane debounce, press/release strobes.
// Optional auto-repeat of press_pulse while held: define BTN_AUTOREPEAT_EN.
module button_debounce_sync #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw_n,
    output logic [NUM_BUTTONS-1:0] btn_clean_n,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [NUM_BUTTONS-1:0] s1_q;
    logic [NUM_BUTTONS-1:0] s2_q;
    logic [NUM_BUTTONS-1:0] clean_q;
    logic [NUM_BUTTONS-1:0] clean_d;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] release_q;
    logic [NUM_BUTTONS-1:0] release_d;
    logic [NUM_BUTTONS-1:0] accept;
    logic [NUM_BUTTONS-1:0] repeat_fire;
    logic [CW-1:0]          cnt_q [NUM_BUTTONS];
    logic [CW-1:0]          cnt_d [NUM_BUTTONS];

    // Any sample that matches the accepted level restarts qualification.
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            clean_d[i]   = clean_q[i];
            cnt_d[i]     = '0;
            accept[i]    = 1'b0;
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i]  = 1'b1;
                    clean_d[i] = s2_q[i];
                    if (s2_q[i] == 1'b0) begin
                        press_d[i] = 1'b1;
                    end else begin
                        release_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            press_d[i] = press_d[i] | repeat_fire[i];
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
    localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_WRAP = HW'(REPEAT_DELAY + REPEAT_PERIOD - 2);

    logic [HW-1:0] hold_q [NUM_BUTTONS];
    logic [HW-1:0] hold_d [NUM_BUTTONS];

    // Hold count loops over [HOLD_FIRE, HOLD_WRAP], one repeat per lap.
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            hold_d[i]      = '0;
            repeat_fire[i] = 1'b0;
            if (!clean_q[i] && !accept[i]) begin
                repeat_fire[i] = (hold_q[i] == HOLD_FIRE);
                if (hold_q[i] >= HOLD_WRAP) begin
                    hold_d[i] = HOLD_FIRE;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign repeat_fire = '0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q      <= '1;
            s2_q      <= '1;
            clean_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn_raw_n;
            s2_q      <= s1_q;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_clean_n   = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debounce_sync.sv
// Directed bench for button_debounce_sync (DEBOUNCE=8, REPEAT 40/10).
// Build with BTN_AUTOREPEAT_EN to exercise the auto-repeat expectations.
module tb_button_debounce_sync;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw_n;
    logic [1:0] btn_clean_n;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [1:0] raw;
        int         n;
        logic [1:0] clean;
        logic [1:0] press;
        logic [1:0] rel;
        int         np;
        int         nr;
    } vec_t;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_HOLD = 6;
    localparam int REP_TAIL = 1;
`else
    localparam int REP_HOLD = 0;
    localparam int REP_TAIL = 0;
`endif

    button_debounce_sync #(
        .NUM_BUTTONS(2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY(40),
        .REPEAT_PERIOD(10)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .btn_raw_n(btn_raw_n),
        .btn_clean_n(btn_clean_n),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply raw for n edges, tally strobes, then check outputs.
    task automatic step(input string tag, input vec_t v);
        int np;
        int nr;
        np = 0;
        nr = 0;
        btn_raw_n = v.raw;
        for (int k = 0; k < v.n; k++) begin
            tick();
            np += $countones(press_pulse);
            nr += $countones(release_pulse);
        end
        chk({tag, " clean"}, int'(btn_clean_n), int'(v.clean));
        chk({tag, " press"}, int'(press_pulse), int'(v.press));
        chk({tag, " release"}, int'(release_pulse), int'(v.rel));
        chk({tag, " npress"}, np, v.np);
        chk({tag, " nrelease"}, nr, v.nr);
    endtask

    vec_t tbl [$];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        btn_raw_n = 2'b11;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Reset asserted asynchronously with both buttons down.
        #2;
        btn_raw_n = 2'b00;
        reset     = 1'b1;
        #1;
        chk("rst clean now", int'(btn_clean_n), 3);
        chk("rst press now", int'(press_pulse), 0);
        chk("rst release now", int'(release_pulse), 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rst held clean", int'(btn_clean_n), 3);
            chk("rst held pulses", int'(press_pulse | release_pulse), 0);
        end
        btn_raw_n = 2'b11;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();

        // clean press lane0
        tbl.push_back('{2'b10, 9, 2'b11, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b10, 1, 2'b10, 2'b01, 2'b00, 1, 0});
        tbl.push_back('{2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0});
        // release lane0 with simultaneous press lane1
        tbl.push_back('{2'b01, 9, 2'b10, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b01, 1, 2'b01, 2'b10, 2'b01, 1, 1});
        tbl.push_back('{2'b01, 1, 2'b01, 2'b00, 2'b00, 0, 0});
        // bounce on lane0: low 5, high 1, then low
        tbl.push_back('{2'b00, 5, 2'b01, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b01, 1, 2'b01, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b00, 9, 2'b01, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b00, 1, 2'b00, 2'b01, 2'b00, 1, 0});
        tbl.push_back('{2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0});
        // both released together
        tbl.push_back('{2'b11, 9, 2'b00, 2'b00, 2'b00, 0, 0});
        tbl.push_back('{2'b11, 1, 2'b11, 2'b00, 2'b11, 0, 2});
        tbl.push_back('{2'b11, 1, 2'b11, 2'b00, 2'b00, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset four cycles into lane0 qualification, button kept down.
        step("pre-rst", '{2'b10, 4, 2'b11, 2'b00, 2'b00, 0, 0});
        reset = 1'b1;
        #1;
        chk("midrst clean", int'(btn_clean_n), 3);
        repeat (2) tick();
        reset = 1'b0;
        step("postrst wait", '{2'b10, 9, 2'b11, 2'b00, 2'b00, 0, 0});
        step("postrst accept", '{2'b10, 1, 2'b10, 2'b01, 2'b00, 1, 0});

        // Long hold after accept, then release.
        step("hold", '{2'b10, 95, 2'b10, 2'b00, 2'b00, REP_HOLD, 0});
        step("hold release", '{2'b11, 25, 2'b11, 2'b00, 2'b00, REP_TAIL, 1});
        step("after release", '{2'b11, 60, 2'b11, 2'b00, 2'b00, 0, 0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
